// File: rtl/peripheral_bcd_display.sv
// peripheral_bcd_display
// Memory-mapped driver for a multiplexed, common-anode, 4-digit 7-segment display.
// Software writes the packed BCD word (digit 0 in [3:0]) into DATA. While scanning
// is enabled, the new word waits in a pending register. It becomes visible at the
// next frame boundary, so a frame never mixes digits from two different words.
//
// Optional build macro: BCD_DISPLAY_PWM_EN
//   When it is defined, CTRL[7:4] is a brightness level (BRIGHT, reset 4'hF).
//   Each digit slot is split into 16 equal phases, and the anode is driven only
//   in phases 0..BRIGHT. REFRESH_DIV must then be a multiple of 16.
//   When it is undefined, CTRL[7:4] reads 0 and the anode is on for the whole slot.
//
// Bus handshake: a register access happens on the clk edge where cs is high
// together with rd or wr. There is no wait state. Read data appears on d_out one
// cycle after the rd edge and holds until the next read.

module peripheral_bcd_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned PRESC_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam logic [4:0] ADDR_DATA   = 5'h04;
  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h0C;

  // Last prescaler value of a digit slot
  localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(REFRESH_DIV - 1);

  // Control and data registers
  logic               en_q, en_d;
  logic               lzb_q, lzb_d;
  logic [15:0]        shown_q, shown_d;
  logic [15:0]        pend_data_q, pend_data_d;
  logic               pend_q, pend_d;

  // Scan timing
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         idx_q, idx_d;

  // Registered outputs
  logic [15:0]        d_out_q, d_out_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;

  // Decode and helper nets
  logic               data_wr, ctrl_wr, rd_en;
  logic               tick, frame_end;
  logic               any_bad;
  logic [15:0]        rd_data;
  logic [3:0]         bright_rd;
  logic [3:0]         cur_nib;
  logic               lead_zero;
  logic [6:0]         cur_seg;
  logic               slot_on;

`ifdef BCD_DISPLAY_PWM_EN
  localparam int unsigned PHASE_LEN = (REFRESH_DIV >= 16) ? (REFRESH_DIV / 16) : 1;
  logic [3:0]         bright_q, bright_d;
  logic [PRESC_W-1:0] phase;

  // Phase within the slot is prescaler / (slot length / 16). The anode is lit for phases 0..BRIGHT.
  assign phase     = presc_q / PRESC_W'(PHASE_LEN);
  assign slot_on   = (phase <= PRESC_W'(bright_q));
  assign bright_rd = bright_q;
`else
  assign slot_on   = 1'b1;
  assign bright_rd = 4'h0;
`endif

  assign data_wr   = cs && wr && (addr == ADDR_DATA);
  assign ctrl_wr   = cs && wr && (addr == ADDR_CTRL);
  assign rd_en     = cs && rd;

  assign tick      = en_q && (presc_q == PRESC_TERM);
  assign frame_end = tick && (idx_q == 2'd3);

  assign d_out     = d_out_q;
  assign an        = an_q;
  assign seg       = seg_q;

  // Active-low segment pattern {g,f,e,d,c,b,a}. A non-BCD nibble shows a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Flag whether any nibble of the displayed word is outside 0..9
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (shown_q[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // Control register next state. BRIGHT exists only in the PWM build.
  always_comb begin
    en_d  = en_q;
    lzb_d = lzb_q;
`ifdef BCD_DISPLAY_PWM_EN
    bright_d = bright_q;
`endif
    if (ctrl_wr) begin
      en_d  = d_in[0];
      lzb_d = d_in[1];
`ifdef BCD_DISPLAY_PWM_EN
      bright_d = d_in[7:4];
`endif
    end
  end

  // Data path. The frame-boundary transfer comes first, so a write on the same
  // edge lands in pending and leaves PEND set.
  always_comb begin
    shown_d     = shown_q;
    pend_data_d = pend_data_q;
    pend_d      = pend_q;
    if (frame_end && pend_q) begin
      shown_d = pend_data_q;
      pend_d  = 1'b0;
    end
    if (data_wr) begin
      if (en_q) begin
        pend_data_d = d_in;
        pend_d      = 1'b1;
      end else begin
        // Nothing is being scanned, so there is no tearing to avoid.
        shown_d = d_in;
        pend_d  = 1'b0;
      end
    end
  end

  // Prescaler and digit index. Both are held at zero while scanning is disabled.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (!en_q) begin
      presc_d = '0;
      idx_d   = 2'd0;
    end else if (tick) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Register read mux. DATA returns the word software will see next.
  always_comb begin
    rd_data = 16'h0000;
    case (addr)
      ADDR_DATA:   rd_data = pend_q ? pend_data_q : shown_q;
      ADDR_CTRL:   rd_data = {8'h00, bright_rd, 2'b00, lzb_q, en_q};
      ADDR_STATUS: rd_data = {12'h000, any_bad, idx_q, pend_q};
      default:     rd_data = 16'h0000;
    endcase
    d_out_d = rd_en ? rd_data : d_out_q;
  end

  // Digit drive for the current index. It is registered, so an and seg switch on the same edge.
  always_comb begin
    cur_nib = shown_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd3:    lead_zero = (shown_q[15:12] == 4'h0);
      2'd2:    lead_zero = (shown_q[15:8]  == 8'h00);
      2'd1:    lead_zero = (shown_q[15:4]  == 12'h000);
      default: lead_zero = 1'b0;
    endcase
    cur_seg = bcd_to_seg(cur_nib);
    an_d    = 4'b1111;
    seg_d   = 7'h7F;
    if (en_q) begin
      an_d  = slot_on ? ~(4'b0001 << idx_q) : 4'b1111;
      seg_d = (lzb_q && lead_zero) ? 7'h7F : cur_seg;
    end
  end

  // All state registers. Asynchronous reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      lzb_q       <= 1'b0;
      shown_q     <= 16'h0000;
      pend_data_q <= 16'h0000;
      pend_q      <= 1'b0;
      presc_q     <= '0;
      idx_q       <= 2'd0;
      d_out_q     <= 16'h0000;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
    end else begin
      en_q        <= en_d;
      lzb_q       <= lzb_d;
      shown_q     <= shown_d;
      pend_data_q <= pend_data_d;
      pend_q      <= pend_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      d_out_q     <= d_out_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

`ifdef BCD_DISPLAY_PWM_EN
  // Brightness register. It resets to full on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bright_q <= 4'hF;
    else        bright_q <= bright_d;
  end
`endif

endmodule

// File: tb/tb_peripheral_bcd_display.sv
// Testbench for peripheral_bcd_display.
// The driver issues one bus cycle per clock. For each cycle it pushes the
// expected {d_out, an, seg} after the coming edge into exp_q. The monitor pops
// one entry after every edge and compares it with the DUT outputs. The reference
// model derives the scan position from elapsed enabled cycles.

module tb_peripheral_bcd_display;

`ifdef BCD_DISPLAY_PWM_EN
  localparam int DIV = 16;
`else
  localparam int DIV = 4;
`endif

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] d_in;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [15:0] d_out;
  logic [3:0]  an;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  peripheral_bcd_display #(.REFRESH_DIV(DIV), .PRESC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .cs(cs), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out), .an(an), .seg(seg)
  );

  // Scoreboard
  logic [26:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [26:0] item;

  // Reference model state
  int          m_cnt;
  logic        m_en, m_lzb, m_pend;
  logic [15:0] m_shown, m_pdata, m_dout;
  logic [3:0]  m_bright;
  logic [6:0]  seg_tab [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_en = 1'b0; m_lzb = 1'b0; m_pend = 1'b0;
    m_shown = 16'h0; m_pdata = 16'h0; m_dout = 16'h0;
`ifdef BCD_DISPLAY_PWM_EN
    m_bright = 4'hF;
`else
    m_bright = 4'h0;
`endif
  endtask

  // Predict outputs after the next edge, then advance the model by one edge
  task automatic model_edge(input logic c, input logic r, input logic w,
                            input logic [4:0] a, input logic [15:0] d);
    int          idx;
    logic [1:0]  idx2;
    logic        bad, boundary;
    logic [3:0]  nib, an_e;
    logic [6:0]  seg_e;
    idx  = (m_cnt / DIV) % 4;
    idx2 = 2'(idx);
    bad  = 1'b0;
    for (int i = 0; i < 4; i++) if (m_shown[4*i +: 4] > 4'd9) bad = 1'b1;
    if (c && r) begin
      case (a)
        5'h04:   m_dout = m_pend ? m_pdata : m_shown;
        5'h08:   m_dout = {8'h00, m_bright, 2'b00, m_lzb, m_en};
        5'h0C:   m_dout = {12'h000, bad, idx2, m_pend};
        default: m_dout = 16'h0000;
      endcase
    end
    an_e = 4'hF; seg_e = 7'h7F;
    if (m_en) begin
      nib = m_shown[4*idx +: 4];
      an_e[idx2] = 1'b0;
      if (m_lzb && idx != 0 && (m_shown >> (4*idx)) == 16'h0) seg_e = 7'h7F;
      else seg_e = seg_tab[nib];
`ifdef BCD_DISPLAY_PWM_EN
      if (((m_cnt % DIV) / (DIV / 16)) > int'(m_bright)) an_e = 4'hF;
`endif
    end
    exp_q.push_back({m_dout, an_e, seg_e});
    boundary = m_en && (((m_cnt + 1) % (4*DIV)) == 0);
    if (m_en) m_cnt = (m_cnt + 1) % (4*DIV);
    else      m_cnt = 0;
    if (boundary && m_pend) begin m_shown = m_pdata; m_pend = 1'b0; end
    if (c && w && a == 5'h04) begin
      if (m_en) begin m_pdata = d; m_pend = 1'b1; end
      else      begin m_shown = d; m_pend = 1'b0; end
    end
    if (c && w && a == 5'h08) begin
      m_en = d[0]; m_lzb = d[1];
`ifdef BCD_DISPLAY_PWM_EN
      m_bright = d[7:4];
`endif
    end
  endtask

  // Driver tasks
  task automatic step(input logic c, input logic r, input logic w,
                      input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = c; rd = r; wr = w; addr = a; d_in = d;
    model_edge(c, r, w, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [15:0] d);
    step(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic bus_rd(input logic [4:0] a);
    step(1'b1, 1'b1, 1'b0, a, 16'h0000);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  // Reset in the middle of a cycle, check the outputs at once, and resync the model
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'h00; d_in = 16'h0;
    #1;
    check("rst_an", {12'h0, an}, 16'h000F);
    check("rst_seg", {9'h0, seg}, 16'h007F);
    check("rst_d_out", d_out, 16'h0000);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare one expected entry after every edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        check("d_out", d_out, item[26:11]);
        check("an", {12'h0, an}, {12'h0, item[10:7]});
        check("seg", {9'h0, seg}, {9'h0, item[6:0]});
      end
    end
  end

  // Stimulus
  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'h00; d_in = 16'h0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #3;
    check("init_an", {12'h0, an}, 16'h000F);
    check("init_seg", {9'h0, seg}, 16'h007F);
    check("init_d_out", d_out, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Register reads after reset
    bus_rd(5'h04); bus_rd(5'h08); bus_rd(5'h0C); idle(2);

    // Basic scan of 1234
    bus_wr(5'h04, 16'h1234);
    bus_wr(5'h08, 16'h0001);
    idle(4*DIV + 3);

    // Tear-free update
    bus_wr(5'h04, 16'h0987);
    bus_rd(5'h0C);
    idle(4*DIV + 2);
    bus_rd(5'h0C);
    bus_rd(5'h04);

    // Leading-zero blanking and dash
    bus_wr(5'h08, 16'h0003);
    bus_wr(5'h04, 16'h0005); idle(8*DIV + 2);
    bus_wr(5'h04, 16'h0000); idle(8*DIV + 2);
    bus_wr(5'h04, 16'h00A0); idle(5*DIV);
    bus_rd(5'h0C); idle(DIV); bus_rd(5'h0C); idle(2);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    bus_wr(5'h04, rand_bcd());
        2:       bus_wr(5'h08, {8'h00, 4'($urandom_range(0, 15)), 2'b00,
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0)});
        3, 4:    bus_rd(5'(4 * $urandom_range(1, 3)));
        5:       bus_rd(5'($urandom_range(0, 31)));
        6:       bus_wr(5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)));
        7:       step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      5'(4 * $urandom_range(1, 3)), 16'($urandom_range(0, 65535)));
        default: idle($urandom_range(1, 3));
      endcase
    end

    // Reset in mid-frame with a word pending
    bus_wr(5'h08, 16'h0001); idle(DIV + 1);
    bus_wr(5'h04, 16'h1357); bus_rd(5'h0C); idle(1);
    async_reset();
    bus_rd(5'h0C); bus_rd(5'h04); bus_rd(5'h08);
    idle(4*DIV);
    bus_wr(5'h08, 16'h0001);
    idle(4*DIV + 2);

    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/peripheral_bcd_display.md
Name: peripheral_bcd_display

Overview:
Memory-mapped peripheral that takes the 4-digit packed BCD result produced by the binary-to-BCD peripheral (software copies it in) and drives a multiplexed, common-anode 4-digit 7-segment display. It contains a refresh prescaler, a digit scanner, tear-free frame-synchronous data update, leading-zero blanking and invalid-digit indication. It sits on the same CPU bus as the BCD converter peripheral, directly downstream of it.

Parameters:
REFRESH_DIV, 16'd50000, clock cycles spent on each digit slot (at least 2)
PRESC_W, 16, width of the prescaler counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
d_in  in  16  bus write data
cs  in  1  chip select
addr  in  5  register address
rd  in  1  read strobe
wr  in  1  write strobe
d_out  out  16  bus read data (registered)
an  out  4  digit anodes, active-low, an[0] = least significant digit
seg  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Register map (decoded only when cs=1):
  - 0x04 DATA (W/R): 4 BCD nibbles; [3:0] is digit 0.
  - 0x08 CTRL (W/R): bit0 EN, bit1 LZB (leading-zero blank); other bits read 0.
  - 0x0C STATUS (R): bit0 PEND, bits[2:1] current digit index, bit3 any shown nibble > 9.
  - Any other address: writes ignored, reads return 0.
- Reads: d_out is loaded on the clk edge where cs && rd, giving 1-cycle latency. It holds its value otherwise.
- DATA reads return the pending value if PEND=1, else the shown value.
- Write to DATA: loads the pending register and sets PEND in the same edge.
- Frame boundary: the tick that advances the digit index from 3 to 0. When PEND=1 at the frame boundary, shown <= pending and PEND <= 0.
- Simultaneous DATA write and frame boundary: the new write goes to pending and PEND stays 1. The old pending value is transferred to shown.
- While EN=0, a DATA write copies to shown immediately, and PEND stays 0.
- Prescaler: counts 0..REFRESH_DIV-1 while EN=1. Tick = terminal count; the counter wraps to 0 on tick.
- Digit index is a 2-bit counter that increments on tick and wraps 3 -> 0.
- an = ~(4'b0001 << idx) when EN=1.
- EN=0: prescaler and index are cleared and held at 0, an=4'b1111, seg=7'h7F.
- EN written 0 -> 1: scanning starts at digit 0, and the first tick occurs REFRESH_DIV cycles later.
- Segment decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble 10..15 shows a dash: 0111111.
- LZB=1: digit i (i = 3..1) is blanked (seg=7'h7F) when it and all higher digits are 0. Digit 0 is never blanked. Dash nibbles count as nonzero.
- an and seg are registered and change together one cycle after idx changes, so no ghosting mix of old and new values.
- Reset (async assert, sync release):
  - d_out=0, an=4'b1111, seg=7'h7F
  - DATA shown/pending=0, PEND=0, CTRL=0
  - prescaler=0, idx=0
- Reset mid-frame discards pending data.

Optional Feature:
Macro BCD_DISPLAY_PWM_EN.
- Defined:
  - CTRL bits[7:4] form BRIGHT (reset 4'hF).
  - Each digit slot is split into 16 equal phases. an is active only during phases p < BRIGHT+1, and seg is unchanged.
  - BRIGHT=15 gives full on; BRIGHT=0 gives 1/16 duty.
  - REFRESH_DIV must then be a multiple of 16.
- Undefined: CTRL bits[7:4] read 0, writes to them are ignored, and the anode is on for the full slot.

Test Plan:
- Reset, then read 0x04, 0x08 and 0x0C -> d_out=0 each, one cycle after rd. an=4'b1111, seg=7'h7F.
- REFRESH_DIV=4, write DATA=16'h1234 with EN=0, then CTRL=1 -> an sequence 1110,1101,1011,0111 at 4-cycle intervals. seg sequence is 0011001, 0110000, 0100100, 1111001.
- REFRESH_DIV=4, EN=1, write DATA=16'h0987 mid-frame -> STATUS.PEND=1. Old digits persist until the 3->0 tick, then the new digits appear and PEND=0.
- CTRL=3 (EN+LZB), DATA=16'h0005 -> digits 3..1 show seg=7'h7F and digit 0 shows 0010010. With DATA=16'h0000, only digit 0 shows 1000000.
- DATA=16'h00A0, CTRL=3 -> digit 1 shows dash 0111111, digit 2 and digit 3 are blanked, and STATUS bit3=1 while it is shown.
- Assert rst_n=0 mid-frame with PEND=1 -> outputs go to reset values immediately, PEND=0, and after release scanning stays off until CTRL is rewritten.
